// File: rtl/clock_pkg.sv
// Shared calendar constants and date helpers.
// Used by the calendar counter and later alarm/blink blocks.
package clock_pkg;

  localparam logic [7:0]  SEC_MAX      = 8'd59;
  localparam logic [7:0]  MIN_MAX      = 8'd59;
  localparam logic [7:0]  HOUR_MAX     = 8'd23;
  localparam logic [7:0]  MONTH_MAX    = 8'd12;

  localparam logic [15:0] YEAR_MIN_DEF = 16'd2000;
  localparam logic [15:0] YEAR_MAX_DEF = 16'd2099;

  localparam logic [7:0]  RST_MONTH    = 8'd1;
  localparam logic [7:0]  RST_DAY      = 8'd1;
  localparam logic [7:0]  RST_HOUR     = 8'd0;
  localparam logic [7:0]  RST_MIN      = 8'd0;
  localparam logic [7:0]  RST_SEC      = 8'd0;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  sec;
  } cal_t;

  function automatic logic is_leap(input logic [15:0] year);
    logic by4;
    logic by100;
    logic by400;
    by4   = (year % 16'd4)   == 16'd0;
    by100 = (year % 16'd100) == 16'd0;
    by400 = (year % 16'd400) == 16'd0;
    return (by4 && !by100) || by400;
  endfunction

  // Zero flags an illegal month so callers reject it for free.
  function automatic logic [7:0] days_in_month(
    input logic [7:0] month,
    input logic       leap
  );
    logic [7:0] d;
    case (month)
      8'd1, 8'd3, 8'd5, 8'd7,
      8'd8, 8'd10, 8'd12: d = 8'd31;
      8'd4, 8'd6,
      8'd9, 8'd11:        d = 8'd30;
      8'd2:               d = leap ? 8'd29 : 8'd28;
      default:            d = 8'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick
// every CLK_HZ enabled cycles.
module tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(CLK_HZ - 1);

  logic [31:0] cnt;

  assign tick = run && (cnt == LAST);

  // Count while running, wrap on the tick, restart on clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 32'd0;
    end else if (run) begin
      cnt <= tick ? 32'd0 : cnt + 32'd1;
    end
  end

endmodule

// File: rtl/calendar_counter.sv
// Gregorian date/time keeper advancing once per second,
// with validated one-cycle load from the set stage.
module calendar_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter logic [15:0] YEAR_MIN = YEAR_MIN_DEF,
  parameter logic [15:0] YEAR_MAX = YEAR_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] set_year,
  input  logic [7:0]  set_month,
  input  logic [7:0]  set_day,
  input  logic [7:0]  set_hour,
  input  logic [7:0]  set_min,
  input  logic [7:0]  set_sec,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  sec,
  output logic        tick_1hz,
  output logic        load_err
);

  cal_t       cur;
  cal_t       adv;
  cal_t       set_v;
  logic       leap_q;
  logic       adv_leap;
  logic       tick;
  logic       accept;
  logic [7:0] set_dim;
  logic [7:0] cur_dim;
  logic       c_sec;
  logic       c_min;
  logic       c_hour;
  logic       c_day;
  logic       c_mon;

  assign set_v = {set_year, set_month, set_day,
                  set_hour, set_min, set_sec};

  assign set_dim = days_in_month(set_month,
                                 is_leap(set_year));

  // set_dim is zero for a bad month, so the day check
  // also rejects it.
  assign accept = load
               && (set_year >= YEAR_MIN)
               && (set_year <= YEAR_MAX)
               && (set_month >= 8'd1)
               && (set_month <= MONTH_MAX)
               && (set_day >= 8'd1)
               && (set_day <= set_dim)
               && (set_hour <= HOUR_MAX)
               && (set_min <= MIN_MAX)
               && (set_sec <= SEC_MAX);

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (accept),
    .tick  (tick)
  );

  assign cur_dim = days_in_month(cur.month, leap_q);

  assign c_sec  = cur.sec == SEC_MAX;
  assign c_min  = c_sec  && (cur.minute == MIN_MAX);
  assign c_hour = c_min  && (cur.hour == HOUR_MAX);
  assign c_day  = c_hour && (cur.day >= cur_dim);
  assign c_mon  = c_day  && (cur.month == MONTH_MAX);

  // Full one-second carry chain from seconds to year.
  always_comb begin
    adv = cur;
    adv.sec = c_sec ? 8'd0 : cur.sec + 8'd1;
    if (c_sec) begin
      adv.minute = c_min ? 8'd0 : cur.minute + 8'd1;
    end
    if (c_min) begin
      adv.hour = c_hour ? 8'd0 : cur.hour + 8'd1;
    end
    if (c_hour) begin
      adv.day = c_day ? 8'd1 : cur.day + 8'd1;
    end
    if (c_day) begin
      adv.month = c_mon ? 8'd1 : cur.month + 8'd1;
    end
    if (c_mon) begin
      adv.year = (cur.year >= YEAR_MAX) ? YEAR_MIN
                                        : cur.year + 16'd1;
    end
    adv_leap = c_mon ? is_leap(adv.year) : leap_q;
  end

  // Field, leap and strobe registers; a good load beats a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= {YEAR_MIN, RST_MONTH, RST_DAY,
                   RST_HOUR, RST_MIN, RST_SEC};
      leap_q   <= is_leap(YEAR_MIN);
      tick_1hz <= 1'b0;
      load_err <= 1'b0;
    end else if (accept) begin
      cur      <= set_v;
      leap_q   <= is_leap(set_year);
      tick_1hz <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= load;
      tick_1hz <= tick;
      if (tick) begin
        cur    <= adv;
        leap_q <= adv_leap;
      end
    end
  end

  assign year   = cur.year;
  assign month  = cur.month;
  assign day    = cur.day;
  assign hour   = cur.hour;
  assign minute = cur.minute;
  assign sec    = cur.sec;

endmodule
